// File: rtl/alu_exec_if.sv
// Request/response bundle between operand fetch and the execution-stage ALU.
// The requester drives operands and flush; the ALU returns busy, valid and results.
interface alu_exec_if #(parameter int WIDTH = 32);
  logic             valid_in;
  logic [4:0]       aluop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             valid_out;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;

  modport master (output valid_in, aluop, a, b, flush,
                  input  busy, valid_out, result, hi, zero, overflow);
  modport slave  (input  valid_in, aluop, a, b, flush,
                  output busy, valid_out, result, hi, zero, overflow);
endinterface

// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle logic/arith ops, plus iterative 32-step
// signed MUL (shift-add) and DIV (restoring) finished by a sign-fix cycle.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_exec_if.slave   io
);
  localparam logic [4:0] ALUOP_ADD = 5'd0,  ALUOP_SUB = 5'd1,  ALUOP_AND = 5'd2;
  localparam logic [4:0] ALUOP_OR  = 5'd3,  ALUOP_XOR = 5'd4,  ALUOP_NOR = 5'd5;
  localparam logic [4:0] ALUOP_SLT = 5'd6,  ALUOP_SLL = 5'd7,  ALUOP_SRL = 5'd8;
  localparam logic [4:0] ALUOP_SRA = 5'd9,  ALUOP_LUI = 5'd10, ALUOP_MOV = 5'd11;
  localparam logic [4:0] ALUOP_BEQ = 5'd12, ALUOP_BNE = 5'd13, ALUOP_MUL = 5'd14;
  localparam logic [4:0] ALUOP_DIV = 5'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_lo, neg_hi, op_div;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q, ovf_q, vld_q, busy;

  logic accept, is_mul, is_div, last;
  assign accept = io.valid_in && !io.flush && (state == S_IDLE);
  assign is_mul = (io.aluop == ALUOP_MUL);
  assign is_div = (io.aluop == ALUOP_DIV) && (io.b != '0);
  assign last   = (cnt == 6'(WIDTH-1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (io.flush) state_nxt = S_IDLE;
    else case (state)
      S_IDLE: if (accept && is_mul)      state_nxt = S_MUL;
              else if (accept && is_div) state_nxt = S_DIV;
      S_MUL, S_DIV: if (last) state_nxt = S_FIX;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb busy = (state != S_IDLE);

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, dif, sc_res, a_abs, b_abs;
  logic             sc_ovf, sc_def, sc_zero;
  assign sum   = io.a + io.b;
  assign dif   = io.a - io.b;
  assign a_abs = io.a[WIDTH-1] ? -io.a : io.a;
  assign b_abs = io.b[WIDTH-1] ? -io.b : io.b;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_def = 1'b1;
    case (io.aluop)
      ALUOP_ADD: begin
        sc_res = sum;
        sc_ovf = (io.a[WIDTH-1] == io.b[WIDTH-1]) && (sum[WIDTH-1] != io.a[WIDTH-1]);
      end
      ALUOP_SUB: begin
        sc_res = dif;
        sc_ovf = (io.a[WIDTH-1] != io.b[WIDTH-1]) && (dif[WIDTH-1] != io.a[WIDTH-1]);
      end
      ALUOP_AND: sc_res = io.a & io.b;
      ALUOP_OR:  sc_res = io.a | io.b;
      ALUOP_XOR: sc_res = io.a ^ io.b;
      ALUOP_NOR: sc_res = ~(io.a | io.b);
      ALUOP_SLT: sc_res = {{(WIDTH-1){1'b0}}, $signed(io.a) < $signed(io.b)};
      ALUOP_SLL: sc_res = io.a << io.b[4:0];
      ALUOP_SRL: sc_res = io.a >> io.b[4:0];
      ALUOP_SRA: sc_res = $signed(io.a) >>> io.b[4:0];
      ALUOP_LUI: sc_res = {io.b[15:0], {(WIDTH-16){1'b0}}};
      ALUOP_MOV: sc_res = io.b;
      ALUOP_BEQ: sc_res = {{(WIDTH-1){1'b0}}, io.a == io.b};
      ALUOP_BNE: sc_res = {{(WIDTH-1){1'b0}}, io.a != io.b};
      ALUOP_DIV: sc_res = '1;  // only reaches here as divide-by-zero
      ALUOP_MUL: sc_res = '0;
      default:   sc_def = 1'b0;
    endcase
  end
  assign sc_zero = sc_def && (sc_res == '0);

  // Iteration step: acc_lo holds multiplier / shifting quotient, opnd the other operand
  logic [WIDTH:0]     mul_sum, r_sh, d_try;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0]   quo_f, rem_f, fix_res, fix_hi;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign r_sh    = {acc_hi, acc_lo[WIDTH-1]};
  assign d_try   = r_sh - {1'b0, opnd};
  assign prod    = {acc_hi, acc_lo};
  assign prod_f  = neg_lo ? -prod : prod;
  assign quo_f   = neg_lo ? -acc_lo : acc_lo;
  assign rem_f   = neg_hi ? -acc_hi : acc_hi;
  assign fix_res = op_div ? quo_f : prod_f[WIDTH-1:0];
  assign fix_hi  = op_div ? rem_f : prod_f[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0; acc_lo <= '0; opnd <= '0;
      neg_lo <= 1'b0; neg_hi <= 1'b0; op_div <= 1'b0; cnt <= '0;
      result_q <= '0; hi_q <= '0; zero_q <= 1'b0; ovf_q <= 1'b0; vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (io.flush) cnt <= '0;
      else case (state)
        S_IDLE: if (accept) begin
          cnt <= '0;
          if (is_mul) begin
            acc_hi <= '0; acc_lo <= b_abs; opnd <= a_abs;
            neg_lo <= io.a[WIDTH-1] ^ io.b[WIDTH-1]; op_div <= 1'b0;
          end else if (is_div) begin
            acc_hi <= '0; acc_lo <= a_abs; opnd <= b_abs;
            neg_lo <= io.a[WIDTH-1] ^ io.b[WIDTH-1]; neg_hi <= io.a[WIDTH-1];
            op_div <= 1'b1;
          end else begin
            result_q <= sc_res; zero_q <= sc_zero; ovf_q <= sc_ovf; vld_q <= 1'b1;
            if (io.aluop == ALUOP_DIV) hi_q <= io.a;
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 6'd1;
        end
        S_DIV: begin
          acc_hi <= d_try[WIDTH] ? r_sh[WIDTH-1:0] : d_try[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], ~d_try[WIDTH]};
          cnt    <= cnt + 6'd1;
        end
        default: begin
          result_q <= fix_res; hi_q <= fix_hi; zero_q <= (fix_res == '0);
          ovf_q <= 1'b0; vld_q <= 1'b1; cnt <= '0;
        end
      endcase
    end
  end

  assign io.busy      = busy;
  assign io.valid_out = vld_q;
  assign io.result    = result_q;
  assign io.hi        = hi_q;
  assign io.zero      = zero_q;
  assign io.overflow  = ovf_q;
endmodule

// File: doc/alu_exec.md
# alu_exec

Execution-stage ALU that consumes the 5-bit ALU operation code produced by instruction decode (`ALUOP_*` encodings from `defines.v`). It sits between the decode/operand-fetch stage and writeback. Most operations finish in one cycle. MUL and DIV run as iterative multi-cycle operations behind a busy/valid handshake. A flush input lets the pipeline abort work in flight on exceptions and ERET.

## Interface
- `WIDTH`, default 32: datapath width. Only 32 is supported; the iteration count equals `WIDTH`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  request strobe. Accepted only when `busy`=0 and `flush`=0.
- `aluop`  in  5  operation code (`ALUOP_*`).
- `a`  in  WIDTH  operand A; rs, or dividend/multiplicand.
- `b`  in  WIDTH  operand B; rt/immediate, or divisor/multiplier. For shifts, `b[4:0]` is the shift amount.
- `flush`  in  1  synchronous abort.
- `busy`  out  1  multi-cycle operation in progress.
- `valid_out`  out  1  one-cycle strobe marking `result`/`hi`/flags as valid.
- `result`  out  WIDTH  main result: low product, quotient, branch flag, etc.
- `hi`  out  WIDTH  high product or remainder. Holds its last value for all other ops.
- `zero`  out  1  `result`==0, registered with `result`.
- `overflow`  out  1  signed overflow for ADD/SUB; 0 for all other ops.

## Operation
- FSM states: IDLE, MUL, DIV, FIX. `busy` = (state != IDLE).
- IDLE, request accepted, single-cycle op: the result is registered at the accepting edge and `valid_out`=1 in the following cycle. State stays IDLE.
  - ADD/SUB: wrap modulo 2^32. `overflow` follows the signed rule: operand signs equal (ADD) or different (SUB), and result sign differs from A.
  - AND/OR/XOR/NOR: bitwise.
  - SLT: signed compare; result 1 or 0.
  - SLL/SRL/SRA: shift `a` by `b[4:0]`. SRA is arithmetic.
  - LUI: `{b[15:0],16'h0}`.
  - MOV: `b`.
  - BEQ: result = (a==b). BNE: result = (a!=b).
  - Undefined code: result 0, flags 0, `valid_out` still pulses.
- IDLE, request accepted, MUL: latch |a| and |b| and the sign of the product, then go to MUL.
  - MUL runs 32 shift-add iterations, one per cycle, then goes to FIX.
- IDLE, request accepted, DIV with b != 0: latch |a|, |b|, the quotient sign (a[31]^b[31]) and the remainder sign (a[31]), then go to DIV.
  - DIV runs 32 restoring-division iterations, then goes to FIX.
- DIV with b==0 is handled as a single-cycle op: result=32'hFFFF_FFFF, hi=a, no FSM entry.
- FIX (one cycle):
  - MUL: conditionally negate the 64-bit product; result=low, hi=high.
  - DIV: negate the quotient and/or the remainder per the latched signs.
  - Then return to IDLE and pulse `valid_out`.
- 0x8000_0000 / -1: result=0x8000_0000, hi=0 (natural wrap, no trap).
- `valid_in` while `busy`=1 is ignored; no queuing.
- `flush`=1:
  - Any state goes to IDLE at the next edge and the iteration counter clears.
  - No `valid_out` is produced for the aborted op.
  - `result`/`hi` keep their prior values.
  - A concurrent `valid_in` is dropped.

## Timing
- Reset (async, while `rst_n`=0): state=IDLE, `busy`=0, `valid_out`=0, `result`=0, `hi`=0, `zero`=0, `overflow`=0, counter=0.
- Single-cycle ops: accepted at edge N; `valid_out`=1 from edge N+1 for exactly one cycle.
- MUL/DIV: accepted at edge N.
  - `busy`=1 after edge N.
  - Iterations run on edges N+1..N+32; FIX on edge N+33.
  - `valid_out`=1 and `busy`=0 after edge N+33, so latency is 33 cycles.
- Back-to-back: a new request may be accepted in the same cycle `valid_out` is high.
- Outputs hold between `valid_out` pulses. `valid_out` never lasts more than one cycle.
- `rst_n` asserted mid-operation: immediate return to the reset values above; no completion pulse afterwards.

## Test plan
- Reset mid-DIV: start DIV 100/7, drop `rst_n` at cycle 10 -> all outputs 0 and `busy`=0 immediately; no `valid_out` after release.
- ADD 0x7FFF_FFFF+1 -> result 0x8000_0000, overflow=1, `valid_out` 1 cycle later. Then SUB 5-5 -> result 0, zero=1, overflow=0.
- MUL -3 x 7 -> after 33 cycles result 0xFFFF_FFEB, hi 0xFFFF_FFFF, `busy` high for exactly 33 cycles.
- DIV -7/2 -> result 0xFFFF_FFFD, hi 0xFFFF_FFFF. DIV 9/0 -> result 0xFFFF_FFFF, hi 9, latency 1.
- Flush at cycle 5 of MUL 6x7 -> `busy`=0 next cycle, no `valid_out`, result unchanged. A following SLL 1<<4 -> result 16.
- `valid_in` pulsed during MUL busy with ADD 1+1 -> ignored. Only the MUL result (e.g. 6x7 -> 42) appears; a back-to-back ADD issued in the `valid_out` cycle yields 2 on the next cycle.
